// File: rtl/ram_stream_fifo_pkg.sv
// Shared constants and width helpers for the RAM-backed streaming FIFO.
package ram_stream_fifo_pkg;

  // Entries in the output skid stage (head + spare).
  localparam int unsigned STAGE_DEPTH = 2;

  // ram_count spans 0..DEPTH, so it needs one bit more than the address.
  function automatic int unsigned ram_count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  // Occupancy spans 0..DEPTH+STAGE_DEPTH.
  function automatic int unsigned occupancy_width(input int unsigned addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/ram_stream_fifo_out_stage.sv
// Two-entry in-order skid stage: head register presented downstream, spare
// register absorbing the word returning from the RAM while the head stalls.
module fifo_out_stage
  import ram_stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);

  localparam logic [1:0] STAGE_FULL = 2'(STAGE_DEPTH);

  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] spare_q, spare_d;
  logic                  pop_ok;

  assign pop_ok = pop && (count_q != 2'd0);
  assign count  = count_q;
  assign head   = head_q;

  // Next-state: shift spare into head on pop, land the pushed word in the
  // first free slot behind whatever remains.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    spare_d = spare_q;
    if (clear) begin
      count_d = 2'd0;
      head_d  = '0;
      spare_d = '0;
    end else if (pop_ok) begin
      if (count_q == STAGE_FULL) begin
        head_d = spare_q;
        if (push) spare_d = push_data;
        else      count_d = 2'd1;
      end else begin
        if (push) head_d  = push_data;
        else      count_d = 2'd0;
      end
    end else if (push) begin
      if (count_q == 2'd0) begin
        head_d  = push_data;
        count_d = 2'd1;
      end else begin
        spare_d = push_data;
        count_d = STAGE_FULL;
      end
    end
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= 2'd0;
      head_q  <= '0;
      spare_q <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      spare_q <= spare_d;
    end
  end

endmodule

// File: rtl/ram_stream_fifo.sv
// Streaming FIFO controller wrapped around an external simple dual-port RAM.
// Handshakes: a word moves on a rising edge when valid && ready are both high
// in that cycle; valid never waits on ready, and in_ready is a function of
// registered state, reset and flush only (no path from out_ready).
module ram_stream_fifo
  import ram_stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [occupancy_width(ADDR_WIDTH)-1:0] occupancy,
  output logic                                  full,
  output logic                                  empty,
  output logic                                  ram_we,
  output logic [ADDR_WIDTH-1:0]                 ram_addr_a,
  output logic [DATA_WIDTH-1:0]                 ram_data_a,
  output logic                                  ram_en_b,
  output logic [ADDR_WIDTH-1:0]                 ram_addr_b,
  input  logic [DATA_WIDTH-1:0]                 ram_data_b
);

  localparam int unsigned CW = ram_count_width(ADDR_WIDTH);
  localparam int unsigned OW = occupancy_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [2:0]    STAGE_LIMIT = 3'(STAGE_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         ram_count_q, ram_count_d;
  logic                  inflight_q, inflight_d;

  logic                  run;
  logic                  ram_full;
  logic                  accept;
  logic                  pop;
  logic                  issue;
  logic                  stage_push;
  logic [1:0]            stage_count;
  logic [DATA_WIDTH-1:0] stage_head;
  logic [2:0]            stage_pending;

  // Normal operation only when out of reset and not flushing.
  assign run      = reset && !flush;
  assign ram_full = (ram_count_q == DEPTH_C);
  assign in_ready = run && !ram_full;
  assign accept   = in_valid && in_ready;

  assign out_valid = reset && (stage_count != 2'd0);
  assign out_data  = reset ? stage_head : '0;
  assign pop       = out_valid && out_ready;

  // Words the stage will hold next cycle if nothing new is issued; a read
  // may go out only if its return is guaranteed a free slot.
  assign stage_pending = {1'b0, stage_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue         = run && (ram_count_q != '0) && (stage_pending < STAGE_LIMIT);

  // A flush or reset cycle discards the word coming back from the RAM.
  assign stage_push = run && inflight_q;

  assign ram_we     = accept;
  assign ram_addr_a = wr_ptr_q;
  assign ram_data_a = in_data;
  assign ram_en_b   = issue;
  assign ram_addr_b = rd_ptr_q;

  assign occupancy = reset ? (OW'(ram_count_q) + OW'(inflight_q) + OW'(stage_count)) : '0;
  assign full      = reset && ram_full;
  assign empty     = (occupancy == '0);

  // Pointer and count bookkeeping; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    inflight_d  = 1'b0;
    if (!run) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_count_d = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (issue)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (accept && !issue) ram_count_d = ram_count_q + 1'b1;
      if (issue && !accept) ram_count_d = ram_count_q - 1'b1;
      inflight_d = issue;
    end
  end

  // Controller registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      inflight_q  <= inflight_d;
    end
  end

  fifo_out_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_stage (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .push      (stage_push),
    .push_data (ram_data_b),
    .pop       (pop),
    .count     (stage_count),
    .head      (stage_head)
  );

endmodule

// File: tb/tb_ram_stream_fifo.sv
// Self-checking bench for ram_stream_fifo with a behavioural RAM and a
// queue-based reference of FIFO contents.
module tb_ram_stream_fifo;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int OW    = AW + 2;

  // Clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] occupancy;
  logic          full;
  logic          empty;
  logic          ram_we;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_data_a;
  logic          ram_en_b;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_data_b;

  ram_stream_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty),
    .ram_we     (ram_we),
    .ram_addr_a (ram_addr_a),
    .ram_data_a (ram_data_a),
    .ram_en_b   (ram_en_b),
    .ram_addr_b (ram_addr_b),
    .ram_data_b (ram_data_b)
  );

  // Scoreboard state
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  int            age_q[$];
  logic [DW-1:0] pop_log[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  int            acc_cnt = 0;
  int            pop_cnt = 0;
  int            first_valid_cyc = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    age_q.delete();
    wr_cnt = 0;
    rd_cnt = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance RAM and reference.
  task automatic tick();
    logic          acc, pop, clr, we, en;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, din;
    @(negedge clock);
    if (!reset) model_clear();
    chk("occupancy", occupancy, exp_q.size());
    chk("empty", empty, exp_q.size() == 0);
    chk("occ_bound", occupancy <= DEPTH + 2, 1);
    if (exp_q.size() == 0) chk("valid_when_empty", out_valid, 0);
    else if (out_valid) chk("head_data", out_data, exp_q[0]);
    if (exp_q.size() != 0 && cyc - age_q[0] >= 3) chk("latency", out_valid, 1);
    if (!reset || flush || exp_q.size() >= DEPTH + 2) chk("in_ready_low", in_ready, 0);
    else if (exp_q.size() < DEPTH) chk("in_ready_high", in_ready, 1);
    if (exp_q.size() < DEPTH) chk("full_low", full, 0);
    else if (exp_q.size() == DEPTH + 2) chk("full_high", full, 1);
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    chk("ram_we", ram_we, acc);
    if (ram_we) begin
      chk("wr_addr", ram_addr_a, wr_cnt % DEPTH);
      chk("wr_data", ram_data_a, in_data);
    end
    if (ram_en_b) begin
      chk("rd_addr", ram_addr_b, rd_cnt % DEPTH);
      chk("rd_underrun", rd_cnt < wr_cnt, 1);
      if (ram_we) chk("rw_collision", ram_addr_a == ram_addr_b, 0);
    end
    if (!reset) begin
      chk("rst_out_data", out_data, 0);
      chk("rst_en_b", ram_en_b, 0);
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (pop) pop_log.push_back(out_data);
    clr = !reset || flush;
    we  = ram_we;
    en  = ram_en_b;
    aa  = ram_addr_a;
    ab  = ram_addr_b;
    da  = ram_data_a;
    din = in_data;
    @(posedge clock);
    if (clr) begin
      model_clear();
    end else begin
      if (pop && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
        pop_cnt++;
      end
      if (acc) begin
        exp_q.push_back(din);
        age_q.push_back(cyc);
        acc_cnt++;
        wr_cnt++;
      end
      if (en) rd_cnt++;
    end
    #1;
    if (en) ram_data_b = mem[ab];
    if (we) mem[aa] = da;
    cyc++;
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    int c0;
    int limit;
    int pv, pr;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; ram_data_b = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("first_ready", in_ready, 1);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_empty", empty, 1);

    // Three words, consumer always ready
    out_ready = 1'b1;
    first_valid_cyc = -1;
    pop_log.delete();
    c0 = cyc;
    in_valid = 1'b1;
    in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    in_data = 32'h33; tick();
    drain(8);
    chk("t1_latency", first_valid_cyc - c0, 3);
    chk("t1_count", pop_log.size(), 3);
    if (pop_log.size() == 3) begin
      chk("t1_w0", pop_log[0], 32'h11);
      chk("t1_w1", pop_log[1], 32'h22);
      chk("t1_w2", pop_log[2], 32'h33);
    end
    chk("t1_empty", empty, 1);

    // Fill to capacity with the consumer stalled
    acc_cnt = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_data = 32'h1000 + i;
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("t2_accepted", acc_cnt, DEPTH + 2);
    chk("t2_occupancy", occupancy, DEPTH + 2);
    chk("t2_full", full, 1);
    chk("t2_in_ready", in_ready, 0);
    chk("t2_empty", empty, 0);
    drain(16);
    chk("t2_drained", empty, 1);

    // Continuous streaming across several pointer wraps
    pop_log.delete();
    pop_cnt = 0;
    acc_cnt = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = 32'h100 + i;
      tick();
    end
    chk("t3_accepts", acc_cnt, 40);
    chk("t3_throughput", pop_cnt, 37);
    drain(6);
    chk("t3_count", pop_log.size(), 40);
    for (int i = 0; i < 40; i++)
      if (i < pop_log.size()) chk("t3_pattern", pop_log[i], 32'h100 + i);

    // Randomised traffic against the reference queue
    acc_cnt = 0;
    limit = 0;
    pv = 70; pr = 70;
    while (acc_cnt < 10000 && limit < 60000) begin
      if (limit % 500 == 0) begin
        pv = $urandom_range(40, 100);
        pr = $urandom_range(40, 100);
      end
      in_valid  = ($urandom_range(0, 99) < pv);
      out_ready = ($urandom_range(0, 99) < pr);
      in_data   = $urandom;
      tick();
      limit++;
    end
    chk("t4_done", acc_cnt >= 10000, 1);
    drain(16);
    chk("t4_empty", empty, 1);

    // Flush with words in the stage and a read in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 32'h500 + i;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("t5_occupancy", occupancy, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_empty", empty, 1);
    pop_log.delete();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hAB;
    tick();
    drain(6);
    chk("t5_next_count", pop_log.size(), 1);
    if (pop_log.size() != 0) chk("t5_next_word", pop_log[0], 32'hAB);

    // Reset pulse in the middle of a stream
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'h700 + i;
      tick();
    end
    reset = 1'b0;
    #1;
    chk("t6_in_ready", in_ready, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_occupancy", occupancy, 0);
    chk("t6_full", full, 0);
    chk("t6_empty", empty, 1);
    chk("t6_ram_we", ram_we, 0);
    chk("t6_ram_en_b", ram_en_b, 0);
    tick();
    reset = 1'b1;
    pop_log.delete();
    first_valid_cyc = -1;
    c0 = cyc;
    in_data = 32'hC0DE;
    tick();
    drain(6);
    chk("t6_latency", first_valid_cyc - c0, 3);
    chk("t6_count", pop_log.size(), 1);
    if (pop_log.size() != 0) chk("t6_word", pop_log[0], 32'hC0DE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
